// File: rtl/param_hist_reg.sv
// Multi-mode WIDTH-bit state register (hold/load/shift/clear) that keeps a
// DEPTH-deep history of its previous values and flags each value change.
module param_hist_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SELW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             sclr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    input  logic [SELW-1:0]  hist_sel,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] hist_dout,
    output logic [WIDTH-1:0] oldest,
    output logic             ser_out,
    output logic             changed,
    output logic [CNTW-1:0]  hist_cnt,
    output logic             hist_full
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_hist [DEPTH];
    logic             r_ser;
    logic             r_changed;
    logic [CNTW-1:0]  r_cnt;

    logic             w_upd;
    logic [WIDTH-1:0] w_nq;
    logic             w_nser;
    logic [WIDTH-1:0] w_hist_mux;

    always_comb begin
        w_upd  = sclr || (mode != MODE_HOLD);
        w_nq   = r_q;
        w_nser = r_ser;
        if (sclr) begin
            w_nq   = '0;
            w_nser = 1'b0;
        end else if (mode == MODE_LOAD) begin
            w_nq = din;
        end else if (mode == MODE_SHL) begin
            w_nq   = {r_q[WIDTH-2:0], sin};
            w_nser = r_q[WIDTH-1];
        end else if (mode != MODE_HOLD) begin
            w_nq   = {sin, r_q[WIDTH-1:1]};
            w_nser = r_q[0];
        end
    end

    // History is pushed on every update cycle, even when the value is unchanged.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_q       <= '0;
            r_ser     <= 1'b0;
            r_changed <= 1'b0;
            r_cnt     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_changed <= w_upd && (w_nq != r_q);
            if (w_upd) begin
                r_q       <= w_nq;
                r_ser     <= w_nser;
                r_hist[0] <= r_q;
                for (int i = 1; i < DEPTH; i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
                if (r_cnt != CNTW'(DEPTH)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Out-of-range selects read zero; a single-entry history ignores the select.
    always_comb begin
        w_hist_mux = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((DEPTH == 1) || (hist_sel == SELW'(i))) begin
                w_hist_mux = r_hist[i];
            end
        end
    end

    assign dout      = r_q;
    assign hist_dout = w_hist_mux;
    assign oldest    = r_hist[DEPTH-1];
    assign ser_out   = r_ser;
    assign changed   = r_changed;
    assign hist_cnt  = r_cnt;
    assign hist_full = (r_cnt == CNTW'(DEPTH));

endmodule

// File: tb/tb_param_hist_reg.sv
// Scoreboard bench for param_hist_reg (WIDTH=8, DEPTH=4): a behavioural model
// queues the expected state per command, popped after the clock edge.
module tb_param_hist_reg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SELW  = 2;
    localparam int CNTW  = 3;

    typedef struct packed {
        logic [WIDTH-1:0]            q;
        logic                        chg;
        logic                        ser;
        logic [CNTW-1:0]             cnt;
        logic                        full;
        logic [DEPTH-1:0][WIDTH-1:0] h;
    } exp_t;

    logic             clk = 1'b0;
    logic             arst;
    logic             sclr;
    logic [1:0]       mode;
    logic [WIDTH-1:0] din;
    logic             sin;
    logic [SELW-1:0]  hist_sel;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] hist_dout;
    logic [WIDTH-1:0] oldest;
    logic             ser_out;
    logic             changed;
    logic [CNTW-1:0]  hist_cnt;
    logic             hist_full;

    param_hist_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .arst     (arst),
        .sclr     (sclr),
        .mode     (mode),
        .din      (din),
        .sin      (sin),
        .hist_sel (hist_sel),
        .dout     (dout),
        .hist_dout(hist_dout),
        .oldest   (oldest),
        .ser_out  (ser_out),
        .changed  (changed),
        .hist_cnt (hist_cnt),
        .hist_full(hist_full)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    exp_t sb [$];

    logic [WIDTH-1:0]            m_q;
    logic [DEPTH-1:0][WIDTH-1:0] m_h;
    logic                        m_ser;
    logic [CNTW-1:0]             m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q   = '0;
        m_h   = '0;
        m_ser = 1'b0;
        m_cnt = '0;
        sb.delete();
    endtask

    task automatic model_step(input logic s, input logic [1:0] m,
                              input logic [WIDTH-1:0] d, input logic b);
        logic [WIDTH-1:0] nq;
        exp_t e;
        e.chg = 1'b0;
        if (s || m != 2'b00) begin
            nq = m_q;
            if (s) begin
                nq = '0;
                m_ser = 1'b0;
            end else begin
                case (m)
                    2'b01: nq = d;
                    2'b10: begin nq = {m_q[WIDTH-2:0], b}; m_ser = m_q[WIDTH-1]; end
                    default: begin nq = {b, m_q[WIDTH-1:1]}; m_ser = m_q[0]; end
                endcase
            end
            e.chg = (nq != m_q);
            for (int i = DEPTH - 1; i > 0; i--) m_h[i] = m_h[i-1];
            m_h[0] = m_q;
            if (m_cnt < CNTW'(DEPTH)) m_cnt = m_cnt + 1'b1;
            m_q = nq;
        end
        e.q    = m_q;
        e.ser  = m_ser;
        e.cnt  = m_cnt;
        e.full = (m_cnt == CNTW'(DEPTH));
        e.h    = m_h;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("dout", 32'(dout), 32'(e.q));
            chk("changed", 32'(changed), 32'(e.chg));
            chk("ser_out", 32'(ser_out), 32'(e.ser));
            chk("hist_cnt", 32'(hist_cnt), 32'(e.cnt));
            chk("hist_full", 32'(hist_full), 32'(e.full));
            chk("oldest", 32'(oldest), 32'(e.h[DEPTH-1]));
            for (int i = 0; i < DEPTH; i++) begin
                hist_sel = SELW'(i);
                #1;
                chk($sformatf("hist_dout[%0d]", i), 32'(hist_dout), 32'(e.h[i]));
            end
            hist_sel = '0;
        end
    endtask

    task automatic step(input logic s, input logic [1:0] m,
                        input logic [WIDTH-1:0] d, input logic b);
        sclr = s; mode = m; din = d; sin = b;
        model_step(s, m, d, b);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        arst = 1'b1;
        #1;
        chk({tag, "_dout"}, 32'(dout), 32'h0);
        chk({tag, "_cnt"}, 32'(hist_cnt), 32'h0);
        chk({tag, "_chg"}, 32'(changed), 32'h0);
        chk({tag, "_ser"}, 32'(ser_out), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            hist_sel = SELW'(i);
            #0.5;
            chk({tag, $sformatf("_hist%0d", i)}, 32'(hist_dout), 32'h0);
        end
        hist_sel = '0;
        model_reset();
        #1;
        arst = 1'b0;
    endtask

    initial begin
        arst = 1'b1; sclr = 1'b0; mode = 2'b00; din = '0; sin = 1'b0; hist_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_cnt", 32'(hist_cnt), 32'h0);
        arst = 1'b0;

        // Get non-zero state, then reset asynchronously between edges.
        step(1'b0, 2'b01, 8'hFF, 1'b0);
        step(1'b0, 2'b10, 8'h00, 1'b0);
        chk("pre_rst_ser", 32'(ser_out), 32'h1);
        async_reset_check("arst1");

        step(1'b0, 2'b01, 8'hA5, 1'b0);
        chk("load_dout", 32'(dout), 32'hA5);
        chk("load_chg", 32'(changed), 32'h1);
        chk("load_cnt", 32'(hist_cnt), 32'h1);
        repeat (3) step(1'b0, 2'b00, 8'h11, 1'b1);
        chk("hold_dout", 32'(dout), 32'hA5);
        chk("hold_chg", 32'(changed), 32'h0);
        chk("hold_cnt", 32'(hist_cnt), 32'h1);

        step(1'b0, 2'b10, 8'h00, 1'b1);
        chk("shl_dout", 32'(dout), 32'h4B);
        chk("shl_ser", 32'(ser_out), 32'h1);
        step(1'b0, 2'b11, 8'h00, 1'b0);
        chk("shr_dout", 32'(dout), 32'h25);
        chk("shr_ser", 32'(ser_out), 32'h1);

        step(1'b0, 2'b01, 8'h3C, 1'b0);
        step(1'b0, 2'b01, 8'h3C, 1'b0);
        chk("same_chg", 32'(changed), 32'h0);

        for (int v = 1; v <= 6; v++) step(1'b0, 2'b01, 8'(v), 1'b0);
        chk("sat_cnt", 32'(hist_cnt), 32'h4);
        chk("sat_full", 32'(hist_full), 32'h1);
        chk("sat_oldest", 32'(oldest), 32'h02);

        step(1'b0, 2'b01, 8'h5A, 1'b0);
        step(1'b1, 2'b01, 8'hFF, 1'b1);
        chk("clr_dout", 32'(dout), 32'h00);
        chk("clr_chg", 32'(changed), 32'h1);
        chk("clr_ser", 32'(ser_out), 32'h0);
        chk("clr_cnt", 32'(hist_cnt), 32'h4);

        step(1'b0, 2'b10, 8'h00, 1'b1);
        async_reset_check("arst2");

        for (int k = 0; k < 30; k++) begin
            step(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                 8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/param_hist_reg.md
Name: param_hist_reg

Overview:
- Parametrised successor to the single-bit load flop, used for sensor and actuator state in the home controller.
- Holds a WIDTH-bit register with several modes: hold, parallel load, shift left, shift right, and synchronous clear.
- Keeps a DEPTH-entry history of previous register values, readable by index.
- Flags value changes, so control logic can detect sensor transitions and look back at recent states.

Parameters:
WIDTH, 8, register and history entry width in bits (>=2)
DEPTH, 4, number of history entries (>=1)
SELW, $clog2(DEPTH) (min 1), width of hist_sel
CNTW, $clog2(DEPTH+1), width of hist_cnt

Ports:
clk  input  1  clock, rising edge
arst  input  1  asynchronous reset, active-high
sclr  input  1  synchronous clear, priority over mode
mode  input  2  00 hold, 01 parallel load, 10 shift left, 11 shift right
din  input  WIDTH  parallel load data
sin  input  1  serial input bit for shifts
hist_sel  input  SELW  history read index, 0 = most recent previous value
dout  output  WIDTH  current register value q
hist_dout  output  WIDTH  hist[hist_sel], combinational
oldest  output  WIDTH  hist[DEPTH-1]
ser_out  output  1  last bit shifted out
changed  output  1  one-cycle pulse: last update changed q
hist_cnt  output  CNTW  number of valid history entries, saturates at DEPTH
hist_full  output  1  hist_cnt == DEPTH

Behaviour:
- Clock and reset: one clock, clk; reset arst is asynchronous and active-high.
- Reset (arst=1, async): q, all hist entries, ser_out, changed and hist_cnt go to 0, immediately and independent of clk. Same effect if arst asserts mid-operation; no partial update survives.
- Update cycle: any rising edge with sclr=1 or mode!=00.
- Next value of q (nq), by priority:
  - sclr=1 -> nq=0; mode ignored; ser_out<=0.
  - mode=01 -> nq=din; ser_out unchanged.
  - mode=10 -> nq={q[WIDTH-2:0],sin}; ser_out<=q[WIDTH-1].
  - mode=11 -> nq={sin,q[WIDTH-1:1]}; ser_out<=q[0].
  - mode=00 and sclr=0 -> hold: q, hist, hist_cnt and ser_out unchanged; changed<=0.
- Latency: q updates at the same edge the command is sampled; dout reflects it in the following cycle. No handshake; a command is taken every cycle.
- History push on every update cycle, even when nq==q: hist[0]<=q (old value), hist[i]<=hist[i-1] for i=1..DEPTH-1, and the hist[DEPTH-1] content is discarded.
- hist_cnt<=min(hist_cnt+1, DEPTH) on each update cycle. It is never decremented except by arst; sclr does not reset it.
- changed<=(update cycle && nq!=q), registered. It is high for exactly one cycle, coincident with the new dout. Back-to-back changing updates keep it high continuously.
- hist_dout:
  - Combinational mux on hist_sel.
  - If hist_sel>=DEPTH (DEPTH not a power of 2), hist_dout=0.
  - Entries with index>=hist_cnt read their reset value 0.
- DEPTH=1: history is a single previous-value register; hist_sel is ignored (hist_dout=hist[0]).
- All outputs except hist_dout come directly from registers, or from a compare on hist_cnt for hist_full.

Test Plan:
- Reset: WIDTH=8, DEPTH=4. Assert arst between edges -> dout=0x00, hist_cnt=0, changed=0, ser_out=0 immediately, before the next clk edge.
- Load: mode=01, din=0xA5 -> next cycle dout=0xA5, changed=1, hist[0]=0x00, hist_cnt=1. Then mode=00 for 3 cycles -> dout stays 0xA5, changed=0, hist_cnt=1.
- Shifts: from 0xA5, mode=10, sin=1 -> dout=0x4B, ser_out=1. Then mode=11, sin=0 -> dout=0x25, ser_out=1, hist_sel=0 gives 0x4B, hist_sel=1 gives 0xA5.
- Same-value load: load 0x3C twice -> second update gives changed=0, hist[0]=0x3C, hist_cnt incremented.
- History saturation: 6 loads 0x01..0x06 -> hist_cnt=4, hist_full=1, oldest=0x02, hist_sel=0 gives 0x05.
- Clear priority: q=0x5A, sclr=1 with mode=01, din=0xFF -> dout=0x00, changed=1, ser_out=0, hist[0]=0x5A. Then arst mid-sequence -> all history reads 0.
